// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-master ROM arbiter: FSM states,
// master indices and the timeout counter width helper.
package rom_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rom_arb_grant.sv
// Combinational winner select between the two masters.
// ROM_ARB_RR_EN selects round-robin; otherwise M0 has fixed priority.
module rom_arb_grant
  import rom_arb_pkg::*;
(
`ifdef ROM_ARB_RR_EN
  input  logic last_i,
`endif
  input  logic stb0_i,
  input  logic stb1_i,
  output logic req_o,
  output logic win_o
);

  always_comb begin
    req_o = stb0_i | stb1_i;
`ifdef ROM_ARB_RR_EN
    // On a tie the master that was not granted last time wins.
    if (stb0_i && stb1_i) win_o = (last_i == M0) ? M1 : M0;
    else                  win_o = stb1_i ? M1 : M0;
`else
    win_o = (!stb0_i && stb1_i) ? M1 : M0;
`endif
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-master Wishbone arbiter in front of a registered-read ROM; one transfer
// in flight, writes and slave timeouts answered with ERR. Macro: ROM_ARB_RR_EN.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT       = 4
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     M0_STB_I,
  input  logic                     M0_WE_I,
  input  logic [ADDRESS_WIDTH-1:0] M0_ADR_I,
  output logic [DATA_WIDTH-1:0]    M0_DAT_O,
  output logic                     M0_ACK_O,
  output logic                     M0_ERR_O,
  input  logic                     M1_STB_I,
  input  logic                     M1_WE_I,
  input  logic [ADDRESS_WIDTH-1:0] M1_ADR_I,
  output logic [DATA_WIDTH-1:0]    M1_DAT_O,
  output logic                     M1_ACK_O,
  output logic                     M1_ERR_O,
  output logic                     S_STB_O,
  output logic                     S_WE_O,
  output logic [ADDRESS_WIDTH-1:0] S_ADR_O,
  input  logic [DATA_WIDTH-1:0]    S_DAT_I,
  input  logic                     S_ACK_I
);

  localparam int CW = cnt_width(TIMEOUT);

  state_e                   state_q, state_d;
  logic                     gnt_q, gnt_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     req, win, we_sel;
`ifdef ROM_ARB_RR_EN
  logic                     last_q, last_d;
`endif

  rom_arb_grant u_grant (
`ifdef ROM_ARB_RR_EN
    .last_i (last_q),
`endif
    .stb0_i (M0_STB_I),
    .stb1_i (M1_STB_I),
    .req_o  (req),
    .win_o  (win)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    adr_d   = adr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    we_sel  = 1'b0;
`ifdef ROM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: if (req) begin
        gnt_d   = win;
        adr_d   = (win == M1) ? M1_ADR_I : M0_ADR_I;
        we_sel  = (win == M1) ? M1_WE_I : M0_WE_I;
        state_d = we_sel ? ST_ERR : ST_ISSUE;
`ifdef ROM_ARB_RR_EN
        last_d  = win;
`endif
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (S_ACK_I) begin
          data_d  = S_DAT_I;
          state_d = ST_RESP;
        end else begin
          // Saturating count; the step that reaches TIMEOUT raises the error.
          if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
          if (cnt_q >= CW'(TIMEOUT - 1)) state_d = ST_ERR;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      gnt_q   <= M0;
      adr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef ROM_ARB_RR_EN
      last_q  <= M0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef ROM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Outputs depend only on registered state.
  assign S_STB_O  = (state_q == ST_ISSUE);
  assign S_WE_O   = 1'b0;
  assign S_ADR_O  = adr_q;
  assign M0_ACK_O = (state_q == ST_RESP) && (gnt_q == M0);
  assign M1_ACK_O = (state_q == ST_RESP) && (gnt_q == M1);
  assign M0_ERR_O = (state_q == ST_ERR)  && (gnt_q == M0);
  assign M1_ERR_O = (state_q == ST_ERR)  && (gnt_q == M1);
  assign M0_DAT_O = M0_ACK_O ? data_q : '0;
  assign M1_DAT_O = M1_ACK_O ? data_q : '0;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-master Wishbone arbiter that shares one single-port ROM slave (registered read, ACK one cycle after STB) between an instruction-fetch master (M0) and a data-load master (M1). It sits between the CPU bus ports and the ROM, and serialises accesses so that exactly one transfer is in flight. Write attempts and unresponsive slaves are answered with an error instead of hanging the master.

## Interface

Parameters:
- ADDRESS_WIDTH, 8, address width for masters and slave.
- DATA_WIDTH, 8, data width.
- TIMEOUT, 4, maximum WAIT cycles for slave ACK before error; must be ≥2.

Ports:
- CLK_I  in  1  sole clock; all logic on posedge.
- RST_I  in  1  synchronous, active-high reset.
- M0_STB_I / M1_STB_I  in  1  master request; held until that master's ACK or ERR.
- M0_WE_I / M1_WE_I  in  1  write enable; writes are rejected.
- M0_ADR_I / M1_ADR_I  in  ADDRESS_WIDTH  read address.
- M0_DAT_O / M1_DAT_O  out  DATA_WIDTH  read data, valid while the matching ACK is high.
- M0_ACK_O / M1_ACK_O  out  1  one-cycle completion pulse.
- M0_ERR_O / M1_ERR_O  out  1  one-cycle error pulse (write or timeout).
- S_STB_O  out  1  strobe to ROM; a one-cycle pulse per access.
- S_WE_O  out  1  tied 0.
- S_ADR_O  out  ADDRESS_WIDTH  address to ROM.
- S_DAT_I  in  DATA_WIDTH  ROM read data.
- S_ACK_I  in  1  ROM acknowledge.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE: sample both STBs; pick a winner (see Configuration); latch the winner index and address. If the winner has WE_I=1, go to ERR; otherwise go to ISSUE. With no STB, stay in IDLE.
- ISSUE: S_STB_O=1 and S_ADR_O=latched address for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT: S_STB_O=0. When S_ACK_I=1, latch S_DAT_I and go to RESP. Otherwise increment the counter. When the counter reaches TIMEOUT, go to ERR.
- RESP: granted master's ACK_O=1 and DAT_O=latched data for one cycle; go to IDLE.
- ERR: granted master's ERR_O=1 for one cycle; go to IDLE. No slave access is made for a write.
- The non-granted master's ACK/ERR stay 0. Its STB stays pending and is arbitrated at the next IDLE.
- S_ACK_I outside WAIT (a late ACK after timeout, or one after reset) is ignored.
- Timeout counter width is clog2(TIMEOUT+1) and saturates; it never wraps.
- A master must drop STB in the cycle after its ACK/ERR. If STB is still high at the next IDLE, that is treated as a new request.

## Timing

- Reset values: state IDLE; all STB/ACK/ERR outputs 0; S_ADR_O, DAT_O, latched data 0; grant pointer = M0.
- Reset during any state returns to IDLE on the next edge. No ACK/ERR is emitted for the aborted transfer.
- Read latency with the standard ROM: STB seen in IDLE at cycle 0, ISSUE at cycle 1, ROM ACK in cycle 2, master ACK in cycle 3.
- Write error latency: IDLE at cycle 0, ERR pulse at cycle 1.
- Timeout error: ERR pulse TIMEOUT+2 cycles after the IDLE sample.
- Back-to-back throughput: one read per 4 cycles.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration

- ROM_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests, the master not granted last wins. The grant pointer updates on every grant, including error grants.
- ROM_ARB_RR_EN undefined: fixed priority, M0 always wins over M1. The grant pointer logic is absent.

## Structure

- Package rom_arb_pkg holds the FSM state enum, the master index constants (M0=0, M1=1) and the timeout counter width function.
- Sub-module rom_arb_grant: combinational winner select from the two STBs and the last-grant pointer. The ROM_ARB_RR_EN selection lives here.

## Test plan

- Single read: M1 reads address 0x10 with ROM[0x10]=0xA5 -> M1_ACK_O high exactly at cycle 3 with DAT 0xA5; M0 outputs stay 0; one S_STB_O pulse.
- Contention: M0 and M1 request together in the same cycle -> without the macro, M0 is served first, then M1. With ROM_ARB_RR_EN and last grant M0, M1 is served first. Repeat 4 times to show alternation under round-robin.
- Write reject: M0 with WE_I=1 to 0x03 -> M0_ERR_O pulses at cycle 1; S_STB_O never asserts.
- Timeout: S_ACK_I forced 0 with TIMEOUT=4 -> ERR at cycle 6. A late S_ACK_I at cycle 7 produces no ACK.
- Reset mid-WAIT: assert RST_I one cycle while in WAIT -> next cycle IDLE with all outputs 0; ROM ACK that cycle is ignored; a subsequent read succeeds normally.
- Held STB: M0 keeps STB high for 2 cycles after ACK -> exactly one extra read is issued, with no duplicate ACK from the first read.
